// File: rtl/rv32i_pkg.sv
// Shared types and constants for the load/store unit: FSM states, response
// error codes and access-size encodings.
package rv32i_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    LSU_ERR_OK          = 2'b00,
    LSU_ERR_LD_MISALIGN = 2'b01,
    LSU_ERR_ST_MISALIGN = 2'b10,
    LSU_ERR_FAULT       = 2'b11
  } lsu_err_t;

  localparam logic [1:0] LSU_SZ_B = 2'b00;
  localparam logic [1:0] LSU_SZ_H = 2'b01;
  localparam logic [1:0] LSU_SZ_W = 2'b10;

  // Low address bits that must be zero for an access of the given size.
  function automatic logic [1:0] lsu_align_mask(input logic [1:0] sz);
    logic [1:0] mask;
    case (sz)
      LSU_SZ_H: mask = 2'b01;
      LSU_SZ_W: mask = 2'b11;
      default:  mask = 2'b00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/lsu_align_check.sv
// Combinational legality decode for a load/store request: access fault
// (illegal size/funct3 or out-of-range address) beats misalignment.
module lsu_align_check
  import rv32i_pkg::*;
#(
  parameter int MEM_BYTES = 32768
) (
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic        we,
  output lsu_err_t    err
);

  logic fault;
  logic misaligned;

  always_comb begin
    fault = (funct3[1:0] == 2'b11)
         || (we && funct3[2])
         || (!we && (funct3 == 3'b110))
         || ({1'b0, addr} >= 33'(MEM_BYTES));
    misaligned = (addr[1:0] & lsu_align_mask(funct3[1:0])) != 2'b00;
    err = LSU_ERR_OK;
    if (fault) begin
      err = LSU_ERR_FAULT;
    end else if (misaligned) begin
      err = we ? LSU_ERR_ST_MISALIGN : LSU_ERR_LD_MISALIGN;
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging a request/response handshake to
// a simple memory port. Optional perf counters via LSU_PERF_CNT_EN.
//
//   state   | meaning
//   IDLE    | ready for a request (req_ready high)
//   RD      | memory read in progress, rd_addr/funct3 driven
//   WR      | one-cycle memory write, wr_en high
//   RESP    | rsp_valid held until rsp_ready
module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int MEM_BYTES = 32768,
  parameter int MEM_WIDTH = $clog2(MEM_BYTES),
  parameter int MLEN      = 64
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_rdata,
  output logic [1:0]           rsp_err,
  output logic [2:0]           funct3,
  output logic [MEM_WIDTH-1:0] rd_addr,
  input  logic [MLEN-1:0]      rd_data,
  output logic [MEM_WIDTH-1:0] wr_addr,
  output logic [MLEN-1:0]      wr_data,
  output logic                 wr_en,
  input  logic [1:0]           error
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]          perf_loads,
  output logic [31:0]          perf_stores,
  output logic [31:0]          perf_faults
`endif
);

  lsu_state_t           state_q, state_d;
  logic                 we_q, we_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [MEM_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [MEM_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [MLEN-1:0]      wr_data_q, wr_data_d;
  logic [31:0]          rdata_q, rdata_d;
  lsu_err_t             err_q, err_d;
  lsu_err_t             chk_err;
  logic                 live_q;

  logic unused_rd_data;
  assign unused_rd_data = ^rd_data[MLEN-1:32];

  lsu_align_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_align_check (
    .funct3(req_funct3),
    .addr  (req_addr),
    .we    (req_we),
    .err   (chk_err)
  );

  // live_q keeps req_ready low while reset is asserted even though state is IDLE.
  assign req_ready = live_q && (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign wr_en     = (state_q == ST_WR);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign funct3    = funct3_q;
  assign rd_addr   = rd_addr_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    funct3_d  = funct3_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          err_d   = chk_err;
          rdata_d = '0;
          if (chk_err != LSU_ERR_OK) begin
            state_d = ST_RESP;
          end else begin
            funct3_d = req_funct3;
            if (req_we) begin
              wr_addr_d = req_addr[MEM_WIDTH-1:0];
              wr_data_d = MLEN'(req_wdata);
              state_d   = ST_WR;
            end else begin
              rd_addr_d = req_addr[MEM_WIDTH-1:0];
              state_d   = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        if (error[0]) begin
          err_d = LSU_ERR_FAULT;
        end else begin
          rdata_d = rd_data[31:0];
        end
        state_d = ST_RESP;
      end
      ST_WR: begin
        if (error[1]) begin
          err_d = LSU_ERR_FAULT;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      live_q    <= 1'b0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= LSU_ERR_OK;
    end else begin
      state_q   <= state_d;
      live_q    <= 1'b1;
      we_q      <= we_d;
      funct3_q  <= funct3_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] loads_q, stores_q, faults_q;
  logic        rsp_hs;

  assign rsp_hs      = rsp_valid && rsp_ready;
  assign perf_loads  = loads_q;
  assign perf_stores = stores_q;
  assign perf_faults = faults_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      loads_q  <= '0;
      stores_q <= '0;
      faults_q <= '0;
    end else if (rsp_hs) begin
      if (err_q != LSU_ERR_OK) begin
        faults_q <= faults_q + 32'd1;
      end else if (we_q) begin
        stores_q <= stores_q + 32'd1;
      end else begin
        loads_q <= loads_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of requests with a byte
// memory model, response scoreboard, plus backpressure and reset sequences.
module tb_load_store_unit;

  localparam int MEM_BYTES = 32768;
  localparam int MEM_WIDTH = 15;
  localparam int MLEN      = 64;

  logic                 clk = 1'b0;
  logic                 aresetn;
  logic                 req_valid, req_ready, req_we;
  logic [2:0]           req_funct3;
  logic [31:0]          req_addr, req_wdata;
  logic                 rsp_valid, rsp_ready;
  logic [31:0]          rsp_rdata;
  logic [1:0]           rsp_err;
  logic [2:0]           funct3;
  logic [MEM_WIDTH-1:0] rd_addr, wr_addr;
  logic [MLEN-1:0]      rd_data, wr_data;
  logic                 wr_en;
  logic [1:0]           mem_error;
`ifdef LSU_PERF_CNT_EN
  logic [31:0]          perf_loads, perf_stores, perf_faults;
`endif

  load_store_unit #(
    .MEM_BYTES(MEM_BYTES),
    .MEM_WIDTH(MEM_WIDTH),
    .MLEN     (MLEN)
  ) dut (
    .clk       (clk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .funct3    (funct3),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .error     (mem_error)
`ifdef LSU_PERF_CNT_EN
    ,
    .perf_loads (perf_loads),
    .perf_stores(perf_stores),
    .perf_faults(perf_faults)
`endif
  );

  always #5 clk = ~clk;

  // Byte memory: performs sign/zero extension on reads, sized writes.
  logic [7:0] mem [MEM_BYTES];
  logic [7:0] b0, b1, b2, b3;

  initial for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'h00;

  always_comb begin
    b0 = mem[rd_addr];
    b1 = mem[rd_addr + 15'd1];
    b2 = mem[rd_addr + 15'd2];
    b3 = mem[rd_addr + 15'd3];
    rd_data = '0;
    case (funct3)
      3'b000:  rd_data[31:0] = {{24{b0[7]}}, b0};
      3'b001:  rd_data[31:0] = {{16{b1[7]}}, b1, b0};
      3'b100:  rd_data[31:0] = {24'h0, b0};
      3'b101:  rd_data[31:0] = {16'h0, b1, b0};
      default: rd_data[31:0] = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data[7:0];
      if (funct3[1:0] != 2'b00) mem[wr_addr + 15'd1] <= wr_data[15:8];
      if (funct3[1:0] == 2'b10) begin
        mem[wr_addr + 15'd2] <= wr_data[23:16];
        mem[wr_addr + 15'd3] <= wr_data[31:24];
      end
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int wr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (wr_en) wr_cnt++;

  typedef struct {
    logic        we;
    logic [31:0] rdata;
    logic [1:0]  err;
  } sb_t;
  sb_t sb_q[$];
  sb_t sb_e;
  int  exp_loads = 0, exp_stores = 0, exp_faults = 0;

  always @(negedge clk) begin
    if (aresetn && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check("rsp_rdata", rsp_rdata, sb_e.rdata);
        check("rsp_err", {30'd0, rsp_err}, {30'd0, sb_e.err});
        if (sb_e.err != 2'b00) exp_faults++;
        else if (sb_e.we) exp_stores++;
        else exp_loads++;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  merr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [1:0] merr, logic [31:0] er, logic [1:0] ee, int el);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.merr = merr;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [MEM_WIDTH-1:0] rd_before;
    int wr_before, lat;
    sb_t e;
    wait_ready();
    rd_before = rd_addr;
    wr_before = wr_cnt;
    mem_error = v.merr;
    e.we = v.we; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb_q.push_back(e);
    drive_req(v.we, v.f3, v.addr, v.wdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.exp_lat == 2 && v.we) begin
      check("wr_en_in_wr", {31'd0, wr_en}, 32'd1);
      check("wr_addr", {17'd0, wr_addr}, {17'd0, v.addr[14:0]});
      check("wr_data_lo", wr_data[31:0], v.wdata);
      check("wr_data_hi", wr_data[63:32], 32'd0);
      check("funct3_wr", {29'd0, funct3}, {29'd0, v.f3});
    end else if (v.exp_lat == 2) begin
      check("rd_addr", {17'd0, rd_addr}, {17'd0, v.addr[14:0]});
      check("funct3_rd", {29'd0, funct3}, {29'd0, v.f3});
      check("wr_en_in_rd", {31'd0, wr_en}, 32'd0);
    end
    wait_valid(lat);
    check("latency", lat, v.exp_lat);
    if (v.exp_lat == 1)
      check("rd_addr_kept", {17'd0, rd_addr}, {17'd0, rd_before});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    mem_error = 2'b00;
    check("wr_en_cycles", wr_cnt - wr_before, (v.we && v.exp_lat == 2) ? 1 : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_rsp_err"}, {30'd0, rsp_err}, 32'd0);
    check({tag, "_funct3"}, {29'd0, funct3}, 32'd0);
    check({tag, "_addrs"}, {2'd0, rd_addr, wr_addr}, 32'd0);
    check({tag, "_wr_data"}, wr_data[31:0] | wr_data[63:32], 32'd0);
`ifdef LSU_PERF_CNT_EN
    check({tag, "_perf"}, perf_loads | perf_stores | perf_faults, 32'd0);
`endif
  endtask

  int lat;

  initial begin
    aresetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0; mem_error = 2'b00;

    vecs.push_back(mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 2'b00, 32'h0, 2'b00, 2));
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 2'b00, 32'hDEADBEEF, 2'b00, 2));
    vecs.push_back(mk(1, 3'b000, 32'h203, 32'h80, 2'b00, 32'h0, 2'b00, 2));
    vecs.push_back(mk(0, 3'b000, 32'h203, 32'h0, 2'b00, 32'hFFFFFF80, 2'b00, 2));
    vecs.push_back(mk(0, 3'b100, 32'h203, 32'h0, 2'b00, 32'h00000080, 2'b00, 2));
    vecs.push_back(mk(0, 3'b001, 32'h101, 32'h0, 2'b00, 32'h0, 2'b01, 1));
    vecs.push_back(mk(1, 3'b010, 32'h102, 32'h11111111, 2'b00, 32'h0, 2'b10, 1));
    vecs.push_back(mk(0, 3'b010, 32'h8000, 32'h0, 2'b00, 32'h0, 2'b11, 1));
    vecs.push_back(mk(1, 3'b110, 32'h100, 32'h0, 2'b00, 32'h0, 2'b11, 1));
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 2'b00, 32'hDEADBEEF, 2'b00, 2));
    vecs.push_back(mk(1, 3'b001, 32'h200, 32'h1234ABCD, 2'b00, 32'h0, 2'b00, 2));
    vecs.push_back(mk(0, 3'b001, 32'h200, 32'h0, 2'b00, 32'hFFFFABCD, 2'b00, 2));
    vecs.push_back(mk(0, 3'b101, 32'h200, 32'h0, 2'b00, 32'h0000ABCD, 2'b00, 2));
    vecs.push_back(mk(0, 3'b010, 32'h200, 32'h0, 2'b00, 32'h8000ABCD, 2'b00, 2));
    vecs.push_back(mk(0, 3'b011, 32'h0, 32'h0, 2'b00, 32'h0, 2'b11, 1));
    vecs.push_back(mk(0, 3'b111, 32'h0, 32'h0, 2'b00, 32'h0, 2'b11, 1));
    vecs.push_back(mk(0, 3'b110, 32'h1, 32'h0, 2'b00, 32'h0, 2'b11, 1));
    vecs.push_back(mk(1, 3'b010, 32'h8001, 32'h0, 2'b00, 32'h0, 2'b11, 1));
    vecs.push_back(mk(1, 3'b100, 32'h0, 32'h0, 2'b00, 32'h0, 2'b11, 1));
    vecs.push_back(mk(0, 3'b010, 32'h7FFE, 32'h0, 2'b00, 32'h0, 2'b01, 1));
    vecs.push_back(mk(0, 3'b000, 32'hFFFFFFFF, 32'h0, 2'b00, 32'h0, 2'b11, 1));
    vecs.push_back(mk(0, 3'b010, 32'h7FFC, 32'h0, 2'b00, 32'h0, 2'b00, 2));
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 2'b01, 32'h0, 2'b11, 2));
    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 2'b10, 32'hDEADBEEF, 2'b00, 2));
    vecs.push_back(mk(1, 3'b010, 32'h300, 32'hCAFEF00D, 2'b10, 32'h0, 2'b11, 2));

    #12;
    check_reset_outputs("por");
    @(negedge clk); aresetn = 1'b1;
    @(posedge clk); #1;
    check("ready_after_por", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Backpressure: response held 5 cycles while a new request waits.
    wait_ready();
    sb_e.we = 1'b0; sb_e.rdata = 32'hDEADBEEF; sb_e.err = 2'b00;
    sb_q.push_back(sb_e);
    drive_req(1'b0, 3'b010, 32'h100, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid(lat);
    check("bp_latency", lat, 2);
    drive_req(1'b1, 3'b010, 32'h304, 32'h0BADF00D);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
      check("bp_wr_en", {31'd0, wr_en}, 32'd0);
    end
    sb_e.we = 1'b1; sb_e.rdata = 32'h0; sb_e.err = 2'b00;
    sb_q.push_back(sb_e);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_next_wr_en", {31'd0, wr_en}, 32'd1);
    check("bp_next_wr_addr", {17'd0, wr_addr}, 32'h304);
    wait_valid(lat);
    check("bp_next_latency", lat, 2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

`ifdef LSU_PERF_CNT_EN
    check("perf_loads", perf_loads, exp_loads);
    check("perf_stores", perf_stores, exp_stores);
    check("perf_faults", perf_faults, exp_faults);
`endif

    // Reset during WR: write dropped, no response.
    wait_ready();
    drive_req(1'b1, 3'b010, 32'h308, 32'h77);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_wr_pre_wr_en", {31'd0, wr_en}, 32'd1);
    #1 aresetn = 1'b0;
    exp_loads = 0; exp_stores = 0; exp_faults = 0;
    #1;
    check_reset_outputs("rst_wr");
    @(negedge clk); aresetn = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_wr_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;
    check("rst_wr_ready", {31'd0, req_ready}, 32'd1);

    // Reset during RESP: response abandoned.
    drive_req(1'b0, 3'b010, 32'h100, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_valid(lat);
    check("rst_resp_pre_valid", {31'd0, rsp_valid}, 32'd1);
    #1 aresetn = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    @(negedge clk); aresetn = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_resp_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    rsp_ready = 1'b0;

    run_vec(mk(0, 3'b010, 32'h100, 32'h0, 2'b00, 32'hDEADBEEF, 2'b00, 2));
`ifdef LSU_PERF_CNT_EN
    check("perf_loads_after_rst", perf_loads, 32'd1);
    check("perf_faults_after_rst", perf_faults, 32'd0);
`endif
    check("sb_drained", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
